speed_detector: RTL
===================

SPEED_DETECTOR -- requirements
Module: speed_detector

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 500, the nominal number of clock cycles in a Speed=01 period; legal values >= 2.
REQ-002 SHALL have port ClockIn, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Pulse, input, 1 bit: enable-pulse stream from a rate divider; synchronous to ClockIn, sampled each posedge.
REQ-005 SHALL have port Speed, output, 2 bits: decoded speed code of the locked stream.
REQ-006 SHALL have port Valid, output, 1 bit: high while Speed is locked.
REQ-007 SHALL have port Error, output, 1 bit: one-cycle pulse flagging an illegal period, a timeout, or loss of lock.
REQ-008 SHALL have port Period, output, W bits, W = $clog2(4*CLOCK_FREQUENCY+2): last measured period in cycles.

Function
REQ-009 SHALL keep a registered counter Count, W bits, holding the cycles elapsed since the last sampled pulse.
REQ-010 Count SHALL load 1 in any cycle where Pulse is sampled high, and otherwise increment by 1.
REQ-011 When Pulse is sampled high outside IDLE, the measured period P SHALL equal the current Count, so pulses at cycles t and t+P yield P.
REQ-012 Period SHALL register P at each such measurement and hold it otherwise.
REQ-013 P SHALL classify as 00 when P=1, 01 when P=CF, 10 when P=2*CF, 11 when P=4*CF (exact match); any other P is illegal.
REQ-014 The FSM SHALL have three states: IDLE, MEASURE and LOCK, with a registered 2-bit Candidate code.
REQ-015 In IDLE, a sampled Pulse SHALL move to MEASURE with no classification and SHALL load Count to 1.
REQ-016 In MEASURE, a first legal P SHALL store Candidate and stay in MEASURE.
REQ-017 In MEASURE, a legal P equal to Candidate SHALL move to LOCK, set Speed=Candidate and set Valid=1, visible the cycle after the pulse.
REQ-018 In MEASURE, a legal P not equal to Candidate SHALL replace Candidate and stay in MEASURE.
REQ-019 An illegal P in MEASURE or LOCK SHALL pulse Error, clear Valid, invalidate Candidate and go to MEASURE.
REQ-020 In LOCK, a legal P equal to Speed SHALL keep LOCK with no output change.
REQ-021 In LOCK, a legal P not equal to Speed SHALL pulse Error, clear Valid, set Candidate=P's code and go to MEASURE.
REQ-022 Timeout: when Count reaches 4*CF+1 with no Pulse in MEASURE or LOCK, the block SHALL pulse Error, clear Valid and go to IDLE.
REQ-023 A Pulse sampled on the timeout cycle SHALL be treated as illegal P per REQ-019, not as a timeout.
REQ-024 Count SHALL never wrap; IDLE holds Count at 0 until a pulse.
REQ-025 Error SHALL be a registered output, high for exactly one cycle per event.
REQ-026 Speed SHALL hold its last locked value while Valid=0.

Reset
REQ-027 Reset high SHALL asynchronously force state=IDLE, Count=0, Candidate invalid, Speed=00, Valid=0, Error=0, Period=0.
REQ-028 Reset SHALL dominate a simultaneous Pulse.
REQ-029 Reset mid-measurement SHALL discard all history, so lock requires two fresh matching periods after release.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, MEASURE, LOCK), the speed-code localparams, and the classify function (P, CF -> code, legal).
REQ-031 The design SHALL contain one sub-module, period_counter, which owns Count, the reload on Pulse and the timeout flag.

Verification (CLOCK_FREQUENCY=4)
REQ-032 Pulses every 4 cycles -> Valid=1, Speed=01 one cycle after the 3rd pulse; Period=4; Error never asserted.
REQ-033 Pulse held high continuously -> Valid=1, Speed=00 after the 3rd sampled pulse; Period=1.
REQ-034 Locked at 16-cycle period, then one period of 8 -> Error one cycle, Valid=0, Candidate=10; the next 8-cycle period gives Valid=1, Speed=10.
REQ-035 Locked at Speed=01, then one period of 6 -> Error, Valid=0, state MEASURE; Period=6.
REQ-036 Locked, then Pulse stops -> Error when Count=17, Valid=0, state IDLE; Speed holds its old value.
REQ-037 Reset asserted between edges during MEASURE, coincident with a Pulse -> outputs clear immediately; the pulse is ignored; relock needs 3 pulses after release.

Source files
------------

// File: rtl/speed_detector_pkg.sv
// Shared types, speed codes and period classification for the speed detector.
package speed_detector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCK    = 2'd2
   } state_e;

   localparam logic [1:0] SPEED_FAST    = 2'b00;
   localparam logic [1:0] SPEED_NOMINAL = 2'b01;
   localparam logic [1:0] SPEED_HALF    = 2'b10;
   localparam logic [1:0] SPEED_QUARTER = 2'b11;

   typedef struct packed {
      logic       legal;
      logic [1:0] code;
   } class_t;

   // Exact-match decode; cf >= 2 keeps the four legal periods distinct.
   function automatic class_t classify(input int unsigned p, input int unsigned cf);
      class_t r;
      r.legal = 1'b1;
      r.code  = SPEED_FAST;
      if (p == 1)
         r.code = SPEED_FAST;
      else if (p == cf)
         r.code = SPEED_NOMINAL;
      else if (p == 2 * cf)
         r.code = SPEED_HALF;
      else if (p == 4 * cf)
         r.code = SPEED_QUARTER;
      else
         r.legal = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/speed_detector_period_counter.sv
// Cycle counter since the last sampled pulse, with the no-pulse timeout flag.
module period_counter
   import speed_detector_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 500,
   localparam int W = $clog2(4 * CLOCK_FREQUENCY + 2)
) (
   input  logic         ClockIn,
   input  logic         Reset,
   input  logic         Pulse,
   input  logic         idle,
   output logic [W-1:0] count,
   output logic         timeout
);

   localparam logic [W-1:0] TIMEOUT_COUNT = W'(4 * CLOCK_FREQUENCY + 1);

   // The FSM leaves MEASURE/LOCK on the timeout cycle, so count never passes TIMEOUT_COUNT.
   assign timeout = !idle && (count == TIMEOUT_COUNT);

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (Pulse)
         count <= W'(1);
      else if (idle || timeout)
         count <= '0;
      else
         count <= count + W'(1);
   end

endmodule

// File: rtl/speed_detector.sv
// Locks onto the period of an enable-pulse stream and reports its speed code.
//
// state   | meaning
// IDLE    | no reference pulse yet; count held at 0
// MEASURE | measuring periods, waiting for two matching legal codes
// LOCK    | Speed/Valid locked; any other period breaks lock
module speed_detector
   import speed_detector_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 500,
   localparam int W = $clog2(4 * CLOCK_FREQUENCY + 2)
) (
   input  logic         ClockIn,
   input  logic         Reset,
   input  logic         Pulse,
   output logic [1:0]   Speed,
   output logic         Valid,
   output logic         Error,
   output logic [W-1:0] Period
);

   state_e       state_q;
   logic [1:0]   cand_q;
   logic         cand_vld_q;
   logic [W-1:0] count;
   logic         timeout;
   logic         idle;
   class_t       cls;

   assign idle = (state_q == IDLE);
   assign cls  = classify(32'(count), CLOCK_FREQUENCY);

   period_counter #(
      .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
   ) u_counter (
      .ClockIn(ClockIn),
      .Reset  (Reset),
      .Pulse  (Pulse),
      .idle   (idle),
      .count  (count),
      .timeout(timeout)
   );

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cand_q     <= SPEED_FAST;
         cand_vld_q <= 1'b0;
         Speed      <= SPEED_FAST;
         Valid      <= 1'b0;
         Error      <= 1'b0;
         Period     <= '0;
      end else begin
         Error <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Pulse)
                  state_q <= MEASURE;
            end
            MEASURE: begin
               if (Pulse) begin
                  Period <= count;
                  if (!cls.legal) begin
                     Error      <= 1'b1;
                     Valid      <= 1'b0;
                     cand_vld_q <= 1'b0;
                  end else if (cand_vld_q && (cls.code == cand_q)) begin
                     state_q <= LOCK;
                     Speed   <= cls.code;
                     Valid   <= 1'b1;
                  end else begin
                     cand_q     <= cls.code;
                     cand_vld_q <= 1'b1;
                  end
               end else if (timeout) begin
                  Error      <= 1'b1;
                  Valid      <= 1'b0;
                  cand_vld_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            LOCK: begin
               if (Pulse) begin
                  Period <= count;
                  if (!cls.legal) begin
                     Error      <= 1'b1;
                     Valid      <= 1'b0;
                     cand_vld_q <= 1'b0;
                     state_q    <= MEASURE;
                  end else if (cls.code != Speed) begin
                     // A new legal code counts as the first of two matching periods.
                     Error      <= 1'b1;
                     Valid      <= 1'b0;
                     cand_q     <= cls.code;
                     cand_vld_q <= 1'b1;
                     state_q    <= MEASURE;
                  end
               end else if (timeout) begin
                  Error      <= 1'b1;
                  Valid      <= 1'b0;
                  cand_vld_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               Valid      <= 1'b0;
               cand_vld_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
